// File: rtl/axi_write_collector.sv
// Pairs an address id with a data word from two packet receivers, strobes one
// register-map write and holds the write response until the responder takes it.
module axi_write_collector #(
   parameter int DATA_WIDTH     = 16,
   parameter int MEM_SIZE       = 64,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      addr_valid,
   input  logic [DATA_WIDTH-1:0]     addr_id,
   input  logic                      data_valid,
   input  logic [DATA_WIDTH-1:0]     data_in,
   output logic                      wr_en,
   output logic [DATA_WIDTH-1:0]     wr_id,
   output logic [DATA_WIDTH-1:0]     wr_data,
   output logic                      resp_valid,
   output logic [1:0]                resp_code,
   input  logic                      resp_ready,
   output logic                      busy,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] WRITE   = 2'd1;
   localparam logic [1:0] RESP    = 2'd2;

   localparam logic [DATA_WIDTH:0] MEM_LIMIT = (DATA_WIDTH+1)'(MEM_SIZE);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [1:0]                state;
   logic                      addr_held;
   logic                      data_held;
   logic [DATA_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     data_q;
   logic [1:0]                resp_code_q;
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

   logic handshake;
   logic addr_load;
   logic data_load;
   logic addr_drop;
   logic data_drop;
   logic id_ok;

   function automatic logic [DROP_CNT_WIDTH-1:0] sat_add(
      input logic [DROP_CNT_WIDTH-1:0] cnt,
      input logic [1:0]                inc
   );
      logic [DROP_CNT_WIDTH:0] sum;
      sum = {1'b0, cnt} + {{(DROP_CNT_WIDTH-1){1'b0}}, inc};
      return sum[DROP_CNT_WIDTH] ? '1 : sum[DROP_CNT_WIDTH-1:0];
   endfunction

   // A latch being cleared by the response handshake accepts a new beat that same edge
   assign handshake = (state == RESP) && resp_ready;
   assign addr_load = addr_valid && (!addr_held || handshake);
   assign data_load = data_valid && (!data_held || handshake);
   assign addr_drop = addr_valid && addr_held && !handshake;
   assign data_drop = data_valid && data_held && !handshake;
   assign id_ok     = {1'b0, addr_q} < MEM_LIMIT;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= COLLECT;
         addr_held   <= 1'b0;
         data_held   <= 1'b0;
         resp_code_q <= RESP_OKAY;
         drop_cnt_q  <= '0;
      end else begin
         addr_held <= addr_load || (addr_held && !handshake);
         data_held <= data_load || (data_held && !handshake);
         if (addr_drop || data_drop)
            drop_cnt_q <= sat_add(drop_cnt_q, {1'b0, addr_drop} + {1'b0, data_drop});
         case (state)
            COLLECT: if (addr_held && data_held) state <= WRITE;
            WRITE: begin
               state       <= RESP;
               resp_code_q <= id_ok ? RESP_OKAY : RESP_SLVERR;
            end
            RESP: if (resp_ready) begin
               state       <= COLLECT;
               resp_code_q <= RESP_OKAY;
            end
            default: state <= COLLECT;
         endcase
      end
   end

   // Held payloads need no reset: they are only visible while in WRITE
   always_ff @(posedge clk) begin
      if (addr_load) addr_q <= addr_id;
      if (data_load) data_q <= data_in;
   end

   assign wr_en      = (state == WRITE) && id_ok;
   assign wr_id      = (state == WRITE) ? addr_q : '0;
   assign wr_data    = (state == WRITE) ? data_q : '0;
   assign resp_valid = (state == RESP);
   assign resp_code  = resp_code_q;
   assign busy       = (state == WRITE) || (state == RESP);
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_axi_write_collector.sv
// Bench for axi_write_collector: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_axi_write_collector;
   localparam int DW = 16;
   localparam int MS = 64;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          av, dv, rr;
   logic [DW-1:0] aid, din;
   logic          wr_en, resp_valid, busy;
   logic [DW-1:0] wr_id, wr_data;
   logic [1:0]    resp_code;
   logic [CW-1:0] drop_cnt;

   axi_write_collector #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .DROP_CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .addr_valid(av), .addr_id(aid),
      .data_valid(dv), .data_in(din),
      .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
      .resp_valid(resp_valid), .resp_code(resp_code), .resp_ready(rr),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one held beat per channel, a pending write, a pending response
   bit m_af, m_df, m_wr, m_rp;
   int m_a, m_d, m_code, m_cnt;
   bit chk_en = 1'b0;

   always @(posedge clk) begin : model
      bit hs, afree, dfree;
      int drops;
      if (rst) begin
         m_af <= 0; m_df <= 0; m_wr <= 0; m_rp <= 0; m_code <= 0; m_cnt <= 0;
      end else begin
         hs    = m_rp && rr;
         afree = !m_af || hs;
         dfree = !m_df || hs;
         drops = int'(av && !afree) + int'(dv && !dfree);
         m_cnt <= (m_cnt + drops > 255) ? 255 : m_cnt + drops;
         if (av && afree) begin m_af <= 1; m_a <= int'(aid); end
         else if (hs) m_af <= 0;
         if (dv && dfree) begin m_df <= 1; m_d <= int'(din); end
         else if (hs) m_df <= 0;
         if (m_rp) begin
            if (rr) begin m_rp <= 0; m_code <= 0; end
         end else if (m_wr) begin
            m_wr <= 0; m_rp <= 1; m_code <= (m_a < MS) ? 0 : 2;
         end else if (m_af && m_df) m_wr <= 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_wr_en", int'(wr_en), int'(m_wr && m_a < MS));
         check("m_wr_id", int'(wr_id), m_wr ? m_a : 0);
         check("m_wr_data", int'(wr_data), m_wr ? m_d : 0);
         check("m_resp_valid", int'(resp_valid), int'(m_rp));
         check("m_resp_code", int'(resp_code), m_rp ? m_code : 0);
         check("m_busy", int'(busy), int'(m_wr || m_rp));
         check("m_drop_cnt", int'(drop_cnt), m_cnt);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      av = 1'b0;
      dv = 1'b0;
   endtask

   typedef struct {
      int            gap;      // data pulse cycle minus addr pulse cycle
      logic [DW-1:0] id;
      logic [DW-1:0] data;
      logic          exp_wr;
      logic [1:0]    exp_code;
   } vec_t;

   vec_t vt[6];

   initial begin
      int ta, td, last;
      vt[0] = '{3,  16'd5,     16'hBEEF, 1'b1, 2'b00};
      vt[1] = '{0,  16'd3,     16'h1234, 1'b1, 2'b00};
      vt[2] = '{-2, 16'd7,     16'h5555, 1'b1, 2'b00};
      vt[3] = '{1,  16'd64,    16'hAAAA, 1'b0, 2'b10};
      vt[4] = '{0,  16'hFFFF,  16'h0001, 1'b0, 2'b10};
      vt[5] = '{0,  16'd63,    16'hFFFF, 1'b1, 2'b00};

      rst = 1'b1; av = 0; dv = 0; rr = 1'b1; aid = '0; din = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_resp_valid", int'(resp_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_drop_cnt", int'(drop_cnt), 0);
      rst = 1'b0;
      chk_en = 1'b1;
      cyc();

      foreach (vt[k]) begin
         ta   = (vt[k].gap < 0) ? -vt[k].gap : 0;
         td   = (vt[k].gap < 0) ? 0 : vt[k].gap;
         last = (ta > td) ? ta : td;
         for (int c = 0; c <= last; c++) begin
            av = (c == ta); aid = vt[k].id;
            dv = (c == td); din = vt[k].data;
            cyc();
         end
         cyc();
         check("tbl_wr_en", int'(wr_en), int'(vt[k].exp_wr));
         check("tbl_wr_id", int'(wr_id), int'(vt[k].id));
         check("tbl_wr_data", int'(wr_data), int'(vt[k].data));
         check("tbl_busy_write", int'(busy), 1);
         cyc();
         check("tbl_resp_valid", int'(resp_valid), 1);
         check("tbl_resp_code", int'(resp_code), int'(vt[k].exp_code));
         check("tbl_wr_en_off", int'(wr_en), 0);
         cyc();
         check("tbl_resp_done", int'(resp_valid), 0);
         check("tbl_idle", int'(busy), 0);
      end

      // Backpressure: three addr pulses while the response is held are dropped
      rr = 1'b0;
      av = 1; aid = 16'd10; dv = 1; din = 16'hCAFE;
      cyc();
      cyc();
      check("bp_wr_id", int'(wr_id), 10);
      cyc();
      for (int i = 0; i < 10; i++) begin
         av = (i % 3 == 1); aid = DW'(20 + i);
         check("bp_resp_valid", int'(resp_valid), 1);
         check("bp_resp_code", int'(resp_code), 0);
         cyc();
      end
      check("bp_drop_cnt", int'(drop_cnt), 3);
      rr = 1'b1; av = 1; aid = 16'd9;
      cyc();
      check("hs_resp_off", int'(resp_valid), 0);
      check("hs_drop_cnt", int'(drop_cnt), 3);
      dv = 1; din = 16'h0BAD;
      cyc();
      cyc();
      check("hs_wr_en", int'(wr_en), 1);
      check("hs_wr_id", int'(wr_id), 9);
      check("hs_wr_data", int'(wr_data), 16'h0BAD);
      cyc();
      cyc();

      // Saturation: 300 dropped addr beats against a full address latch
      av = 1; aid = 16'd1;
      cyc();
      for (int i = 0; i < 300; i++) begin
         av = 1; aid = DW'(i);
         cyc();
      end
      check("sat_drop_cnt", int'(drop_cnt), 255);

      // Reset while a response is pending
      rr = 1'b0; dv = 1; din = 16'h7777;
      cyc();
      cyc();
      cyc();
      check("rr_resp_pending", int'(resp_valid), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rr_resp_valid", int'(resp_valid), 0);
      check("rr_busy", int'(busy), 0);
      check("rr_drop_cnt", int'(drop_cnt), 0);
      check("rr_wr_en", int'(wr_en), 0);
      cyc();
      check("rr_no_resp", int'(resp_valid), 0);
      rr = 1'b1; av = 1; aid = 16'd4; dv = 1; din = 16'h4444;
      cyc();
      cyc();
      check("fresh_wr_en", int'(wr_en), 1);
      check("fresh_wr_id", int'(wr_id), 4);
      cyc();
      check("fresh_resp", int'(resp_valid), 1);
      cyc();

      // Randomized traffic, checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         av  = ($urandom_range(0, 3) == 0);
         aid = ($urandom_range(0, 9) == 0) ? 16'hFFFF : DW'($urandom_range(0, 70));
         dv  = ($urandom_range(0, 3) == 0);
         din = DW'($urandom);
         rr  = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 499) == 0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0; av = 0; dv = 0; rr = 1'b1;
      repeat (5) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
